// File: rtl/line_backing_memory.sv
// line_backing_memory: whole-line backing store below the data cache.
// It serves one line read (refill) or line write (write-back) at a time,
// and each access takes a fixed number of cycles (LATENCY).
//
// Handshake: the requester asserts is_input_valid with exactly one of
// mem_read / mem_write set. The request is accepted on a rising edge where
// mem_ready is high. Address, operation and write data are captured at that
// edge, so the requester may change or drop its inputs right afterwards.
// A request with both or neither op bit set is never accepted and gets no
// response. Exactly one response pulse follows each accepted request:
// is_output_valid for a read (dout is valid in the same cycle and holds the
// value afterwards) or is_write_done for a write.
module line_backing_memory #(
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_BLOCKS = 256,
  parameter int LATENCY    = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    is_output_valid,
  output logic                    is_write_done,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    mem_ready,
  output logic [1:0]              state_dbg
);

  localparam int LINE_BITS = BLOCK_SIZE * 8;
  localparam int IDX_BITS  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int CNT_BITS  = 10;
  localparam logic [CNT_BITS-1:0] LAT_M1 = CNT_BITS'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [CNT_BITS-1:0]   counter;
  logic [IDX_BITS-1:0]   idx_q;
  logic                  op_write_q;
  logic [LINE_BITS-1:0]  din_q;
  logic [LINE_BITS-1:0]  mem [NUM_BLOCKS];
  logic                  accept;

  // Line address bits above the index simply wrap onto the same lines.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, addr[31:IDX_BITS]};

  // A request is taken only when idle and carrying exactly one operation.
  assign accept    = (state == IDLE) && is_input_valid && (mem_read ^ mem_write);
  assign mem_ready = (state == IDLE);
  assign state_dbg = state;

  // Request FSM: capture at accept, count down the latency, then touch the array once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      counter         <= '0;
      idx_q           <= '0;
      op_write_q      <= 1'b0;
      din_q           <= '0;
      is_output_valid <= 1'b0;
      is_write_done   <= 1'b0;
      dout            <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      is_output_valid <= 1'b0;
      is_write_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q      <= addr[IDX_BITS-1:0];
            op_write_q <= mem_write;
            din_q      <= din;
            counter    <= LAT_M1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (counter != '0) begin
            counter <= counter - 1'b1;
          end else begin
            state <= DONE;
            if (op_write_q) begin
              mem[idx_q]    <= din_q;
              is_write_done <= 1'b1;
            end else begin
              dout            <= mem[idx_q];
              is_output_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_backing_memory.sv
// Bench for line_backing_memory: one instance at LATENCY=4 for the directed
// timing/data steps and one at LATENCY=1 for a cache-style held handshake.
module tb_line_backing_memory;

  localparam int W = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // LATENCY=4 instance signals
  logic          v4, rd4, wr4, ov4, wd4, rdy4;
  logic [31:0]   a4;
  logic [W-1:0]  din4, dout4;
  logic [1:0]    st4;

  // LATENCY=1 instance signals
  logic          v1, rd1, wr1, ov1, wd1, rdy1;
  logic [31:0]   a1;
  logic [W-1:0]  din1, dout1;
  logic [1:0]    st1;

  line_backing_memory #(.BLOCK_SIZE(16), .NUM_BLOCKS(256), .LATENCY(4)) dut4 (
    .clk(clk), .reset(rst), .is_input_valid(v4), .addr(a4), .mem_read(rd4),
    .mem_write(wr4), .din(din4), .is_output_valid(ov4), .is_write_done(wd4),
    .dout(dout4), .mem_ready(rdy4), .state_dbg(st4)
  );

  line_backing_memory #(.BLOCK_SIZE(16), .NUM_BLOCKS(256), .LATENCY(1)) dut1 (
    .clk(clk), .reset(rst), .is_input_valid(v1), .addr(a1), .mem_read(rd1),
    .mem_write(wr1), .din(din1), .is_output_valid(ov1), .is_write_done(wd1),
    .dout(dout1), .mem_ready(rdy1), .state_dbg(st1)
  );

  // ---------------- scoreboard state ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp1_q[$];
  logic [W-1:0] model4 [256];
  logic [W-1:0] model1 [256];
  int wr_pend4 = 0;
  int wr_pend1 = 0;
  int pulses1  = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: every response pulse must match an outstanding request.
  always @(negedge clk) begin
    if (!rst) begin
      if (ov4) begin
        check("l4_read_outstanding", W'(exp_q.size() > 0), W'(1));
        if (exp_q.size() > 0) check("l4_read_data", dout4, exp_q.pop_front());
      end
      if (wd4) begin
        check("l4_write_outstanding", W'(wr_pend4 > 0), W'(1));
        if (wr_pend4 > 0) wr_pend4--;
      end
      if (ov1 || wd1) pulses1++;
      if (ov1) begin
        check("l1_read_outstanding", W'(exp1_q.size() > 0), W'(1));
        if (exp1_q.size() > 0) check("l1_read_data", dout1, exp1_q.pop_front());
      end
      if (wd1) begin
        check("l1_write_outstanding", W'(wr_pend1 > 0), W'(1));
        if (wr_pend1 > 0) wr_pend1--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One-cycle request on the LATENCY=4 instance, then follow it to completion.
  task automatic req4(input bit wr, input logic [31:0] a, input logic [W-1:0] d);
    int lat;
    int low;
    check("l4_ready_before_req", W'(rdy4), W'(1));
    v4 = 1'b1; rd4 = !wr; wr4 = wr; a4 = a; din4 = d;
    if (wr) begin
      model4[a[7:0]] = d;
      wr_pend4++;
    end else begin
      exp_q.push_back(model4[a[7:0]]);
    end
    @(posedge clk); #1;
    v4 = 1'b0; rd4 = 1'b0; wr4 = 1'b0;
    a4 = 32'($urandom); din4 = {4{32'($urandom)}};
    lat = 0;
    low = 0;
    while (!(ov4 || wd4) && lat < 64) begin
      if (!rdy4) low++;
      @(posedge clk); #1;
      lat++;
    end
    if (!rdy4) low++;
    check("l4_latency", W'(lat), W'(4));
    check("l4_ready_low_cycles", W'(low), W'(5));
    check("l4_write_done_kind", W'(wd4), W'(wr));
    check("l4_output_valid_kind", W'(ov4), W'(!wr));
    @(posedge clk); #1;
    check("l4_pulse_one_cycle", W'(ov4 | wd4), W'(0));
    check("l4_ready_after", W'(rdy4), W'(1));
  endtask

  // Cache-style request on the LATENCY=1 instance: valid held until the pulse.
  task automatic req1(input bit wr, input logic [31:0] a, input logic [W-1:0] d, output int edges);
    edges = 0;
    v1 = 1'b1; rd1 = !wr; wr1 = wr; a1 = a; din1 = d;
    if (wr) begin
      model1[a[7:0]] = d;
      wr_pend1++;
    end else begin
      exp1_q.push_back(model1[a[7:0]]);
    end
    @(posedge clk); #1;
    edges++;
    while (!(ov1 || wd1) && edges < 64) begin
      @(posedge clk); #1;
      edges++;
    end
    check("l1_latency", W'(edges), W'(2));
    check("l1_write_done_kind", W'(wd1), W'(wr));
    v1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
    @(posedge clk); #1;
    edges++;
    check("l1_ready_after", W'(rdy1), W'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] line_a;
    logic [W-1:0] line_b;
    int any_pulse;
    int not_ready;
    int e_w;
    int e_r;

    for (int i = 0; i < 256; i++) begin
      model4[i] = '0;
      model1[i] = '0;
    end
    rst = 1'b1;
    v4 = 1'b0; rd4 = 1'b0; wr4 = 1'b0; a4 = '0; din4 = '0;
    v1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; a1 = '0; din1 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_ready", W'(rdy4), W'(1));
    check("rst_dout", dout4, '0);
    check("rst_state", W'(st4), W'(0));
    check("rst_pulses", W'(ov4 | wd4), W'(0));
    check("rst_ready_l1", W'(rdy1), W'(1));

    // Idle for 20 cycles with no requests.
    any_pulse = 0;
    not_ready = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ov4 || wd4) any_pulse++;
      if (!rdy4) not_ready++;
    end
    check("idle_no_pulse", W'(any_pulse), W'(0));
    check("idle_ready", W'(not_ready), W'(0));

    // Write then read back.
    req4(1'b1, 32'h3, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    req4(1'b0, 32'h3, '0);
    check("read_back_dout_hold", dout4, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);

    // Index wrap.
    req4(1'b1, 32'h105, {4{32'h11111111}});
    req4(1'b0, 32'h005, '0);
    req4(1'b0, 32'h006, '0);

    // Illegal requests: both ops, then neither.
    any_pulse = 0;
    not_ready = 0;
    v4 = 1'b1; rd4 = 1'b1; wr4 = 1'b1; a4 = 32'h3; din4 = {4{32'h55555555}};
    repeat (10) begin
      @(posedge clk); #1;
      if (ov4 || wd4) any_pulse++;
      if (!rdy4) not_ready++;
    end
    rd4 = 1'b0; wr4 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ov4 || wd4) any_pulse++;
      if (!rdy4) not_ready++;
    end
    v4 = 1'b0;
    check("illegal_no_pulse", W'(any_pulse), W'(0));
    check("illegal_ready", W'(not_ready), W'(0));
    req4(1'b0, 32'h3, '0);

    // Reset in the middle of a write.
    v4 = 1'b1; rd4 = 1'b0; wr4 = 1'b1; a4 = 32'h7; din4 = {4{32'hAAAAAAAA}};
    @(posedge clk); #1;
    v4 = 1'b0; wr4 = 1'b0;
    check("midrst_accepted", W'(rdy4), W'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) model4[i] = '0;
    check("midrst_ready", W'(rdy4), W'(1));
    check("midrst_dout", dout4, '0);
    any_pulse = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ov4 || wd4) any_pulse++;
    end
    check("midrst_no_pulse", W'(any_pulse), W'(0));
    req4(1'b0, 32'h7, '0);
    req4(1'b0, 32'h3, '0);

    // Random traffic over a small address window so reads hit earlier writes.
    for (int n = 0; n < 8; n++) begin
      req4(1'($urandom_range(0, 1)), {24'($urandom_range(0, 3)), 8'($urandom_range(0, 7))},
           {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)});
    end

    // LATENCY=1 cache-style: preload, dirty-evict write, refill read.
    line_a = {4{32'h0BADF00D}};
    line_b = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    req1(1'b1, 32'h41, line_b, e_w);
    req1(1'b1, 32'h20, line_a, e_w);
    req1(1'b0, 32'h41, '0, e_r);
    check("l1_evict_refill_cycles", W'(e_w + e_r), W'(6));
    check("l1_refill_dout", dout1, line_b);
    req1(1'b0, 32'h20, '0, e_r);
    repeat (4) @(posedge clk);
    #1;
    check("l1_one_access_per_req", W'(pulses1), W'(4));

    // ---------------- final report ----------------
    check("l4_queue_drained", W'(exp_q.size()), W'(0));
    check("l4_writes_drained", W'(wr_pend4), W'(0));
    check("l1_queue_drained", W'(exp1_q.size()), W'(0));
    check("l1_writes_drained", W'(wr_pend1), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
